// File: rtl/gf2div_pkg.sv
// Shared configuration package for the carry-less (GF(2)) divider.
// Holds the core configuration record and the RemSel result-select encoding.
package gf2div_pkg;

    // Core configuration record; the divider only looks at ZBC_SUPPORTED.
    typedef struct packed {
        logic ZBC_SUPPORTED;
    } cvw_t;

    localparam cvw_t CVW_DEFAULT = '{ZBC_SUPPORTED: 1'b1};

    // RemSel encoding: which half of the division is returned on Result.
    localparam logic REMSEL_QUOT = 1'b0;
    localparam logic REMSEL_REM  = 1'b1;

endpackage

// File: rtl/gf2div_priorityencoder.sv
// Index of the most significant set bit of a word; returns 0 for an all-zero
// input (the divider never uses the index when the divisor is zero).
module priorityencoder #(
    parameter int WIDTH = 32,
    parameter int YW    = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] a,
    output logic [YW-1:0]    y
);

    // Scan upward so the highest set bit is the last one to write y.
    always_comb begin
        y = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (a[i]) y = YW'(i);
        end
    end

endmodule

// File: rtl/gf2div.sv
// Bit-serial GF(2) polynomial divider: one dividend bit per cycle, quotient
// and remainder built by shift/XOR long division.
//
//   state | meaning
//   IDLE  | waiting for StartE; Result/DivZero hold the last completed op
//   BUSY  | one long-division step per cycle, counter walks WIDTH-1 .. 0
//   DONE  | single cycle, Done pulse, Result/DivZero valid
import gf2div_pkg::*;

module gf2div #(
    parameter cvw_t P     = CVW_DEFAULT,
    parameter int   WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             StartE,
    input  logic             FlushE,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             W64,
    input  logic             RemSel,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic             DivZero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Select quotient or remainder; word ops sign-extend from bit 31.
    function automatic logic [WIDTH-1:0] pick(
        input logic             rs,
        input logic             ext,
        input logic [WIDTH-1:0] q,
        input logic [WIDTH-1:0] r
    );
        logic [WIDTH-1:0] v;
        v = (rs == REMSEL_REM) ? r : q;
        if (ext) begin
            for (int i = 32; i < WIDTH; i++) v[i] = v[31];
        end
        return v;
    endfunction

    generate
    if (P.ZBC_SUPPORTED) begin : g_div

        state_t           state_q, state_d;
        logic             wide_op;
        logic [WIDTH-1:0] a_ext, b_ext;
        logic             b_zero;
        logic [CW-1:0]    d_in;
        logic             accept;
        logic             finish;

        logic [WIDTH-1:0] a_q, b_q, r_q, q_q;
        logic [CW-1:0]    cnt_q, d_q;
        logic             w64_q, remsel_q;
        logic [WIDTH-1:0] result_q;
        logic             divzero_q;

        logic [WIDTH-1:0] t, r_nxt, q_nxt;

        // Word operations only exist on the 64-bit build; drop the upper half.
        always_comb begin
            wide_op = (WIDTH == 64) && W64;
            a_ext   = A;
            b_ext   = B;
            if (wide_op) begin
                for (int i = 32; i < WIDTH; i++) begin
                    a_ext[i] = 1'b0;
                    b_ext[i] = 1'b0;
                end
            end
            b_zero = (b_ext == '0);
        end

        priorityencoder #(.WIDTH(WIDTH)) u_msb (
            .a (b_ext),
            .y (d_in)
        );

        // One long-division step: bring down the next dividend bit, subtract
        // (XOR) the divisor whenever the partial remainder reaches degree d.
        always_comb begin
            t = {r_q[WIDTH-2:0], a_q[cnt_q]};
            if (t[d_q]) begin
                r_nxt = t ^ b_q;
                q_nxt = {q_q[WIDTH-2:0], 1'b1};
            end else begin
                r_nxt = t;
                q_nxt = {q_q[WIDTH-2:0], 1'b0};
            end
        end

        // Next state and status outputs; FlushE overrides every transition.
        always_comb begin
            state_d = state_q;
            accept  = 1'b0;
            finish  = 1'b0;
            Busy    = (state_q != IDLE);
            Done    = (state_q == DONE);
            case (state_q)
                IDLE: begin
                    if (StartE) begin
                        accept  = !FlushE;
                        state_d = b_zero ? DONE : BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_q == '0) begin
                        finish  = !FlushE;
                        state_d = DONE;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
            if (FlushE) state_d = IDLE;
        end

        // State register.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) state_q <= IDLE;
            else        state_q <= state_d;
        end

        // Operand latch and shift/XOR datapath registers.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                a_q      <= '0;
                b_q      <= '0;
                r_q      <= '0;
                q_q      <= '0;
                cnt_q    <= '0;
                d_q      <= '0;
                w64_q    <= 1'b0;
                remsel_q <= 1'b0;
            end else if (accept) begin
                a_q      <= a_ext;
                b_q      <= b_ext;
                r_q      <= b_zero ? a_ext : '0;
                q_q      <= '0;
                cnt_q    <= CW'(WIDTH - 1);
                d_q      <= d_in;
                w64_q    <= wide_op;
                remsel_q <= RemSel;
            end else if (state_q == BUSY && !FlushE) begin
                r_q      <= r_nxt;
                q_q      <= q_nxt;
                cnt_q    <= cnt_q - 1'b1;
            end
        end

        // Result/DivZero are captured once per operation so they stay stable
        // through DONE and IDLE until the next accepted start.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                result_q  <= '0;
                divzero_q <= 1'b0;
            end else if (accept && b_zero) begin
                result_q  <= pick(RemSel, wide_op, '0, a_ext);
                divzero_q <= 1'b1;
            end else if (finish) begin
                result_q  <= pick(remsel_q, w64_q, q_nxt, r_nxt);
                divzero_q <= 1'b0;
            end
        end

        assign Result  = result_q;
        assign DivZero = divzero_q;

    end else begin : g_nodiv

        assign Busy    = 1'b0;
        assign Done    = 1'b0;
        assign Result  = '0;
        assign DivZero = 1'b0;

    end
    endgenerate

endmodule
